// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit scheduler.
package uart_pkg;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned BAUD        = 115_200;
    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned BIT_IDX_W   = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period enable generator: one-cycle tick every DIV clocks, held at zero by clr.
module uart_baud_tick #(
    parameter int unsigned DIV = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter feeding one 8N1 UART transmitter from two byte requesters.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = CLK_FREQ_HZ,
    parameter int unsigned BAUD_RATE = BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic                 last_q, last_d;
    logic                 grant_id_d;
    logic                 tx_d;
    logic                 busy_d;
    logic                 win_c;
    logic                 tick_clr_c;
    logic                 tick;

    // Counter idles at zero so every frame starts with a full bit period.
    assign tick_clr_c = (state_q == ST_IDLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr_c),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        last_d     = last_q;
        grant_id_d = grant_id;
        win_c      = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last wins.
                    win_c      = (req0 && req1) ? ~last_q : req1;
                    ack0       = ~win_c;
                    ack1       = win_c;
                    shift_d    = win_c ? data1 : data0;
                    last_d     = win_c;
                    grant_id_d = win_c;
                    bit_idx_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level is registered from the next state so tx changes with the state.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            last_q    <= 1'b1;
            grant_id  <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            last_q    <= last_d;
            grant_id  <= grant_id_d;
            tx        <= tx_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized and directed bench for uart_tx_sched against a frame-timing reference model.
module tb_uart_tx_sched;

    localparam int unsigned D     = 10;
    localparam int unsigned FRAME = 10 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       ack0, ack1, tx, busy, grant_id;

    logic       dreq = 1'b0;
    logic [7:0] ddata = 8'h00;
    logic       dack0, dack1, dtx, dbusy, dgid;

    int         n_vec = 0;
    int         n_err = 0;
    longint     cyc = 0;

    // Reference model: a frame occupies cycles g+1 .. g+FRAME after grant cycle g.
    longint     m_g = -1_000_000;
    logic [7:0] m_byte = 8'h00;
    logic       m_last = 1'b1;
    logic       m_gid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sched #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .data0    (data0),
        .ack0     (ack0),
        .req1     (req1),
        .data1    (data1),
        .ack1     (ack1),
        .tx       (tx),
        .busy     (busy),
        .grant_id (grant_id)
    );

    uart_tx_sched dut_def (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (dreq),
        .data0    (ddata),
        .ack0     (dack0),
        .req1     (1'b0),
        .data1    (8'h00),
        .ack1     (dack1),
        .tx       (dtx),
        .busy     (dbusy),
        .grant_id (dgid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        longint     k;
        logic       e_busy, e_tx, e_a0, e_a1, win;
        logic [9:0] frame;
        int         b;
        if (!rst_n) begin
            m_g    = -1_000_000;
            m_last = 1'b1;
            m_gid  = 1'b0;
        end else begin
            k      = cyc - m_g;
            e_busy = (k >= 1) && (k <= longint'(FRAME));
            frame  = {1'b1, m_byte, 1'b0};
            e_tx   = 1'b1;
            if (e_busy) begin
                b    = int'((k - 1) / longint'(D));
                e_tx = frame[b];
            end
            e_a0 = 1'b0;
            e_a1 = 1'b0;
            win  = 1'b0;
            if (!e_busy && (req0 || req1)) begin
                win  = (req0 && req1) ? ~m_last : req1;
                e_a0 = ~win;
                e_a1 = win;
            end
            check("tx", 32'(tx), 32'(e_tx));
            check("busy", 32'(busy), 32'(e_busy));
            check("grant_id", 32'(grant_id), 32'(m_gid));
            check("ack0", 32'(ack0), 32'(e_a0));
            check("ack1", 32'(ack1), 32'(e_a1));
            if (e_a0 || e_a1) begin
                m_g    = cyc;
                m_byte = win ? data1 : data0;
                m_last = win;
                m_gid  = win;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_acks", 32'({ack0, ack1}), 32'(0));
        check("rst_gid", 32'(grant_id), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag, input int limit, output logic id);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(ack0 || ack1) && i < limit);
        check({tag, "_seen"}, 32'(ack0 || ack1), 32'(1));
        id = ack1;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (busy && i < 3 * FRAME);
        check({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    task automatic drive_random(input int ncyc);
        logic a0, a1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            a0 = ack0;
            a1 = ack1;
            @(posedge clk);
            #1;
            if (a0) begin
                req0  = ($urandom_range(0, 2) == 0);
                data0 = 8'($urandom);
            end else if (!req0) begin
                if ($urandom_range(0, 7) == 0) begin
                    req0  = 1'b1;
                    data0 = 8'($urandom);
                end
            end else if ($urandom_range(0, 299) == 0) begin
                req0 = 1'b0;
            end
            if (a1) begin
                req1  = ($urandom_range(0, 2) == 0);
                data1 = 8'($urandom);
            end else if (!req1) begin
                if ($urandom_range(0, 7) == 0) begin
                    req1  = 1'b1;
                    data1 = 8'($urandom);
                end
            end else if ($urandom_range(0, 299) == 0) begin
                req1 = 1'b0;
            end
        end
    endtask

    initial begin
        logic   id;
        longint ta;
        int     nb, nl, i;

        // Single byte 0x55 from requester 0.
        do_reset();
        @(posedge clk);
        #1 req0 = 1'b1; data0 = 8'h55;
        wait_grant("t1", 20, id);
        check("t1_id", 32'(id), 32'(0));
        @(posedge clk);
        #1 req0 = 1'b0;
        nb = 0;
        for (int j = 0; j < FRAME + 20; j++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("t1_busy_len", 32'(nb), 32'(FRAME));

        // Simultaneous requests then continuous contention: strict alternation.
        do_reset();
        @(posedge clk);
        #1 req0 = 1'b1; req1 = 1'b1; data0 = 8'hA3; data1 = 8'h3C;
        wait_grant("tie", 5, id);
        check("tie_first", 32'(id), 32'(0));
        ta = cyc;
        for (int f = 1; f < 4; f++) begin
            @(posedge clk);
            #1;
            if (id) data1 = 8'($urandom);
            else    data0 = 8'($urandom);
            wait_grant("alt", 2 * FRAME, id);
            check($sformatf("alt_id%0d", f), 32'(id), 32'(f % 2));
            if (f == 1) check("tie_gap", 32'(cyc - ta), 32'(FRAME + 1));
        end
        @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;
        wait_idle("alt");

        // Requester 1 alone, two bytes back to back.
        @(posedge clk);
        #1 req1 = 1'b1; data1 = 8'hFF;
        wait_grant("b2b_a", 20, id);
        check("b2b_a_id", 32'(id), 32'(1));
        ta = cyc;
        @(posedge clk);
        #1 data1 = 8'h00;
        wait_grant("b2b_b", 2 * FRAME, id);
        check("b2b_b_id", 32'(id), 32'(1));
        check("b2b_gap", 32'(cyc - ta), 32'(FRAME + 1));
        @(posedge clk);
        #1 req1 = 1'b0;
        wait_idle("b2b");

        // Reset during data bit 3 of 0x0F with requester 1 still pending.
        do_reset();
        @(posedge clk);
        #1 req0 = 1'b1; data0 = 8'h0F;
        wait_grant("mr", 20, id);
        @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b1; data1 = 8'($urandom);
        repeat (43) @(posedge clk);
        #1;
        check("mr_pre_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mr_tx", 32'(tx), 32'(1));
        check("mr_busy", 32'(busy), 32'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_grant("mr_post", 5, id);
        check("mr_post_id", 32'(id), 32'(1));
        @(posedge clk);
        #1 req1 = 1'b0;
        nb = 0;
        for (int j = 0; j < FRAME + 20; j++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("mr_frame_len", 32'(nb), 32'(FRAME));

        // Randomized traffic.
        do_reset();
        drive_random(4000);
        @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;
        wait_idle("rand");

        // Default parameters: byte 0x00, 868-cycle bits.
        @(posedge clk);
        #1 dreq = 1'b1; ddata = 8'h00;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!dack0 && i < 5);
        check("def_ack", 32'(dack0), 32'(1));
        @(posedge clk);
        #1 dreq = 1'b0;
        nb = 0;
        nl = 0;
        for (int j = 0; j < 9000; j++) begin
            @(negedge clk);
            if (dbusy) nb++;
            if (!dtx) nl++;
        end
        check("def_frame_len", 32'(nb), 32'(8680));
        check("def_low_cycles", 32'(nl), 32'(9 * 868));
        check("def_tx_idle", 32'(dtx), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
